// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage with PC, IF/ID register, stall, redirect/flush and ECALL halt.
// Optional perf counters (fetch/stall/flush) when IF_STAGE_PERF_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       ifid_pc,
  output logic [31:0]       ifid_pc4,
  output logic [31:0]       ifid_inst,
  output logic              ifid_valid,
  output logic              halted
`ifdef IF_STAGE_PERF_EN
  ,output logic [31:0]      fetch_cnt,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  typedef enum logic {RUN, HALT} state_t;
  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx, w_pc4, w_redirect_pc;
  logic [31:0] r_ifid_pc, w_ifid_pc_nx, r_ifid_pc4, w_ifid_pc4_nx;
  logic [31:0] r_ifid_inst, w_ifid_inst_nx;
  logic        r_ifid_valid, w_ifid_valid_nx;
  logic        w_load, w_ecall, w_flush;
  assign imem_addr  = r_pc[ADDR_W+1:2];
  assign ifid_pc    = r_ifid_pc;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_inst  = r_ifid_inst;
  assign ifid_valid = r_ifid_valid;
  assign halted     = r_state == HALT;
  // A real fetch happens only in RUN with neither redirect nor stall; HALT fetches bubbles.
  always_comb begin
    w_pc4           = r_pc + 32'd4;
    w_redirect_pc   = redirect_target & 32'hFFFF_FFFC;
    w_ecall         = imem_data == 32'h0000_0073;
    w_load          = !redirect_valid && !stall && r_state == RUN;
    w_flush         = redirect_valid || (!stall && r_state == HALT);
    w_pc_nx         = redirect_valid ? w_redirect_pc : (w_load && !w_ecall) ? w_pc4 : r_pc;
    w_ifid_pc_nx    = w_load ? r_pc : r_ifid_pc;
    w_ifid_pc4_nx   = w_load ? w_pc4 : r_ifid_pc4;
    w_ifid_inst_nx  = w_flush ? NOP_INST : w_load ? imem_data : r_ifid_inst;
    w_ifid_valid_nx = w_flush ? 1'b0 : w_load ? 1'b1 : r_ifid_valid;
    w_state_nx      = redirect_valid ? RUN : (w_load && w_ecall) ? HALT : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_ifid_pc    <= w_ifid_pc_nx;
      r_ifid_pc4   <= w_ifid_pc4_nx;
      r_ifid_inst  <= w_ifid_inst_nx;
      r_ifid_valid <= w_ifid_valid_nx;
    end
  end
`ifdef IF_STAGE_PERF_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt, r_flush_cnt;
  logic        w_stall_run;
  assign w_stall_run = r_state == RUN && stall && !redirect_valid;
  assign fetch_cnt   = r_fetch_cnt;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + {31'd0, w_load};
      r_stall_cnt <= r_stall_cnt + {31'd0, w_stall_run};
      r_flush_cnt <= r_flush_cnt + {31'd0, redirect_valid};
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + random-stall/redirect bench for if_stage with a per-cycle reference model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_target, imem_data;
  logic [5:0]  imem_addr;
  logic [31:0] ifid_pc, ifid_pc4, ifid_inst;
  logic        ifid_valid, halted;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif
  logic [31:0] mem [64];
  int          passed = 0, total = 0;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_fc, m_sc, m_flc, d;
  logic        m_valid, m_halt, m_init = 1'b0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst),
    .ifid_valid(ifid_valid), .halted(halted)
`ifdef IF_STAGE_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask

  // Reference model: one fetch-stage step per clock, straight from the behavioural rules.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_inst = 32'h33; m_valid = 0; m_halt = 0;
      m_fc = 0; m_sc = 0; m_flc = 0; m_init = 1'b1;
    end else if (redirect_valid) begin
      m_pc = {redirect_target[31:2], 2'b00}; m_inst = 32'h33; m_valid = 0; m_halt = 0; m_flc++;
    end else if (stall) begin
      if (!m_halt) m_sc++;
    end else if (m_halt) begin
      m_inst = 32'h33; m_valid = 0;
    end else begin
      d = mem[m_pc[7:2]];
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = d; m_valid = 1; m_fc++;
      if (d == 32'h73) m_halt = 1; else m_pc = m_pc + 4;
    end
  end

  always @(negedge clk) if (m_init) begin
    chk("addr", {26'd0, imem_addr}, {26'd0, m_pc[7:2]});
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc4", ifid_pc4, m_ipc4);
    chk("ifid_inst", ifid_inst, m_inst);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
`ifdef IF_STAGE_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_flc);
`endif
  end

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect_valid = r; redirect_target = t;
    @(negedge clk);
  endtask

  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h13 | (i << 20);
    mem[0] = 32'h0020_81B3; mem[1] = 32'h0000_A103; mem[2] = 32'h0020_E233;
    mem[3] = 32'h0020_8233; mem[5] = 32'h0000_0073;
    rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    repeat (2) @(negedge clk);
    chk("rst_addr", {26'd0, imem_addr}, 0); chk("rst_valid", {31'd0, ifid_valid}, 0);
    chk("rst_inst", ifid_inst, 32'h33); chk("rst_pc", ifid_pc, 0); chk("rst_halt", {31'd0, halted}, 0);
    rst = 0;
    step(0, 0, 0);
    chk("f0_pc", ifid_pc, 0); chk("f0_inst", ifid_inst, 32'h0020_81B3);
    chk("f0_valid", {31'd0, ifid_valid}, 1); chk("f0_addr", {26'd0, imem_addr}, 1);
    step(0, 0, 0);
    chk("f1_pc", ifid_pc, 4); chk("f1_addr", {26'd0, imem_addr}, 2);
    repeat (3) begin
      step(1, 0, 0);
      chk("st_addr", {26'd0, imem_addr}, 2); chk("st_pc", ifid_pc, 4); chk("st_inst", ifid_inst, 32'h0000_A103);
    end
    step(0, 0, 0);
    chk("rel_pc", ifid_pc, 8); chk("rel_addr", {26'd0, imem_addr}, 3);
    step(0, 0, 0);
    chk("f3_pc", ifid_pc, 12); chk("f3_addr", {26'd0, imem_addr}, 4);
    step(0, 1, 32'h44);
    chk("rd_valid", {31'd0, ifid_valid}, 0); chk("rd_inst", ifid_inst, 32'h33);
    chk("rd_addr", {26'd0, imem_addr}, 17); chk("rd_pc_hold", ifid_pc, 12);
    step(0, 0, 0);
    chk("rd2_pc", ifid_pc, 32'h44); chk("rd2_inst", ifid_inst, 32'h0110_0013);
    step(1, 1, 32'h23);
    chk("srd_addr", {26'd0, imem_addr}, 8); chk("srd_valid", {31'd0, ifid_valid}, 0);
    step(0, 1, 32'h14);
    chk("ec_addr0", {26'd0, imem_addr}, 5);
    step(0, 0, 0);
    chk("ec_inst", ifid_inst, 32'h73); chk("ec_pc", ifid_pc, 32'h14);
    chk("ec_halt", {31'd0, halted}, 1); chk("ec_addr", {26'd0, imem_addr}, 5);
    step(0, 0, 0);
    chk("h_valid", {31'd0, ifid_valid}, 0); chk("h_halt", {31'd0, halted}, 1); chk("h_addr", {26'd0, imem_addr}, 5);
    step(1, 0, 0);
    chk("hs_valid", {31'd0, ifid_valid}, 0); chk("hs_halt", {31'd0, halted}, 1);
    step(0, 1, 0);
    chk("hr_halt", {31'd0, halted}, 0); chk("hr_addr", {26'd0, imem_addr}, 0);
    step(0, 0, 0);
    chk("hr_inst", ifid_inst, 32'h0020_81B3); chk("hr_pc", ifid_pc, 0);
    step(0, 1, 32'hFC);
    chk("w_addr63", {26'd0, imem_addr}, 63);
    step(0, 0, 0);
    chk("w_pc", ifid_pc, 32'hFC); chk("w_inst", ifid_inst, 32'h03F0_0013); chk("w_addr0", {26'd0, imem_addr}, 0);
    step(0, 0, 0);
    chk("w2_pc", ifid_pc, 32'h100); chk("w2_inst", ifid_inst, 32'h0020_81B3); chk("w2_addr", {26'd0, imem_addr}, 1);
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("top_pc", ifid_pc, 32'hFFFF_FFFC); chk("top_pc4", ifid_pc4, 0); chk("top_addr", {26'd0, imem_addr}, 0);
    rst = 1;
    step(1, 1, 32'h40);
    chk("mr_addr", {26'd0, imem_addr}, 0); chk("mr_valid", {31'd0, ifid_valid}, 0);
    chk("mr_halt", {31'd0, halted}, 0); chk("mr_pc", ifid_pc, 0);
`ifdef IF_STAGE_PERF_EN
    chk("mr_fc", fetch_cnt, 0); chk("mr_sc", stall_cnt, 0); chk("mr_flc", flush_cnt, 0);
`endif
    rst = 0;
    step(0, 1, 32'h14);
    step(0, 0, 0);
    chk("hb_halt", {31'd0, halted}, 1);
    rst = 1;
    step(0, 0, 0);
    chk("hrst_halt", {31'd0, halted}, 0); chk("hrst_addr", {26'd0, imem_addr}, 0);
    rst = 0;
    repeat (400) step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom & 32'h0000_01FF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
